// File: rtl/wb_stage.sv
// Writeback stage: 1-cycle registered regfile write for ALU results; loads wait for dmem_rvalid_i, then extend and write.
// mem_ready_o is low only while a load waits on memory. Optional debug trace ports via WB_TRACE_EN.
module wb_stage #(
    parameter int RegW     = 32,
    parameter int RegAddrW = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_valid_i,
    output logic                mem_ready_o,
    input  logic [31:0]         mem_pc_i,
    input  logic [RegAddrW-1:0] mem_rd_i,
    input  logic                mem_rf_we_i,
    input  logic [RegW-1:0]     mem_result_i,
    input  logic                mem_is_load_i,
    input  logic [2:0]          mem_load_op_i,
    input  logic [1:0]          mem_addr_lo_i,
    input  logic                dmem_rvalid_i,
    input  logic [RegW-1:0]     dmem_rdata_i,
    output logic                rf_we_o,
    output logic [RegAddrW-1:0] rf_waddr_o,
    output logic [RegW-1:0]     rf_wdata_o,
    output logic                fwd_valid_o,
    output logic [RegAddrW-1:0] fwd_rd_o,
    output logic [RegW-1:0]     fwd_data_o,
    output logic                fwd_pending_o,
    output logic                retire_o,
`ifdef WB_TRACE_EN
    output logic [31:0]         debug_wb_pc_o,
    output logic [3:0]          debug_wb_rf_we_o,
    output logic [4:0]          debug_wb_rf_wnum_o,
    output logic [31:0]         debug_wb_rf_wdata_o,
`endif
    output logic [31:0]         retire_pc_o
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_LOAD = 2'd1;
    localparam logic [1:0] WRITE     = 2'd2;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    logic [1:0]          state_q, state_d;
    logic [RegAddrW-1:0] ld_rd_q, ld_rd_d;
    logic                ld_we_q, ld_we_d;
    logic [2:0]          ld_op_q, ld_op_d;
    logic [1:0]          ld_lo_q, ld_lo_d;
    logic [31:0]         ld_pc_q, ld_pc_d;

    logic                rf_we_q, rf_we_d;
    logic [RegAddrW-1:0] rf_waddr_q, rf_waddr_d;
    logic [RegW-1:0]     rf_wdata_q, rf_wdata_d;
    logic                retire_q, retire_d;
    logic [31:0]         retire_pc_q, retire_pc_d;

    logic accept;

    function automatic logic [RegW-1:0] load_extend(input logic [2:0] op,
                                                    input logic [1:0] lo,
                                                    input logic [RegW-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lo +: 8];
        h = word[16*lo[1] +: 16];
        case (op)
            OP_LB:   load_extend = {{(RegW-8){b[7]}}, b};
            OP_LBU:  load_extend = {{(RegW-8){1'b0}}, b};
            OP_LH:   load_extend = {{(RegW-16){h[15]}}, h};
            OP_LHU:  load_extend = {{(RegW-16){1'b0}}, h};
            default: load_extend = word;
        endcase
    endfunction

    assign mem_ready_o = (state_q != WAIT_LOAD);
    assign accept      = mem_valid_i & mem_ready_o;

    always_comb begin
        state_d     = state_q;
        ld_rd_d     = ld_rd_q;
        ld_we_d     = ld_we_q;
        ld_op_d     = ld_op_q;
        ld_lo_d     = ld_lo_q;
        ld_pc_d     = ld_pc_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = '0;
        rf_wdata_d  = '0;
        retire_d    = 1'b0;
        retire_pc_d = '0;
        case (state_q)
            WAIT_LOAD: begin
                if (dmem_rvalid_i) begin
                    state_d     = WRITE;
                    rf_we_d     = ld_we_q & (ld_rd_q != '0);
                    rf_waddr_d  = ld_rd_q;
                    rf_wdata_d  = load_extend(ld_op_q, ld_lo_q, dmem_rdata_i);
                    retire_d    = 1'b1;
                    retire_pc_d = ld_pc_q;
                end
            end
            // IDLE and WRITE behave alike; an unused encoding also lands here and recovers.
            default: begin
                if (accept && mem_is_load_i) begin
                    state_d = WAIT_LOAD;
                    ld_rd_d = mem_rd_i;
                    ld_we_d = mem_rf_we_i;
                    ld_op_d = mem_load_op_i;
                    ld_lo_d = mem_addr_lo_i;
                    ld_pc_d = mem_pc_i;
                end else if (accept) begin
                    state_d     = WRITE;
                    rf_we_d     = mem_rf_we_i & (mem_rd_i != '0);
                    rf_waddr_d  = mem_rd_i;
                    rf_wdata_d  = mem_result_i;
                    retire_d    = 1'b1;
                    retire_pc_d = mem_pc_i;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ld_rd_q     <= '0;
            ld_we_q     <= 1'b0;
            ld_op_q     <= '0;
            ld_lo_q     <= '0;
            ld_pc_q     <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            retire_q    <= 1'b0;
            retire_pc_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_rd_q     <= ld_rd_d;
            ld_we_q     <= ld_we_d;
            ld_op_q     <= ld_op_d;
            ld_lo_q     <= ld_lo_d;
            ld_pc_q     <= ld_pc_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            retire_q    <= retire_d;
            retire_pc_q <= retire_pc_d;
        end
    end

    assign rf_we_o       = rf_we_q;
    assign rf_waddr_o    = rf_waddr_q;
    assign rf_wdata_o    = rf_wdata_q;
    assign retire_o      = retire_q;
    assign retire_pc_o   = retire_pc_q;

    assign fwd_pending_o = (state_q == WAIT_LOAD);
    assign fwd_valid_o   = (state_q == WRITE) & rf_we_q;
    assign fwd_rd_o      = (state_q == WAIT_LOAD) ? ld_rd_q :
                           (state_q == WRITE)     ? rf_waddr_q : '0;
    assign fwd_data_o    = (state_q == WRITE) ? rf_wdata_q : '0;

`ifdef WB_TRACE_EN
    assign debug_wb_pc_o       = retire_pc_q;
    assign debug_wb_rf_we_o    = {4{rf_we_q}};
    assign debug_wb_rf_wnum_o  = rf_waddr_q;
    assign debug_wb_rf_wdata_o = rf_wdata_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: reset, ALU writes, load extension, rd=0, streaming, reset mid-load.
module tb_wb_stage;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [31:0] mem_pc_i;
    logic [4:0]  mem_rd_i;
    logic        mem_rf_we_i;
    logic [31:0] mem_result_i;
    logic        mem_is_load_i;
    logic [2:0]  mem_load_op_i;
    logic [1:0]  mem_addr_lo_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
    logic        fwd_pending_o;
    logic        retire_o;
    logic [31:0] retire_pc_o;
`ifdef WB_TRACE_EN
    logic [31:0] debug_wb_pc_o;
    logic [3:0]  debug_wb_rf_we_o;
    logic [4:0]  debug_wb_rf_wnum_o;
    logic [31:0] debug_wb_rf_wdata_o;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    wb_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .mem_pc_i(mem_pc_i), .mem_rd_i(mem_rd_i), .mem_rf_we_i(mem_rf_we_i),
        .mem_result_i(mem_result_i), .mem_is_load_i(mem_is_load_i),
        .mem_load_op_i(mem_load_op_i), .mem_addr_lo_i(mem_addr_lo_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
        .fwd_pending_o(fwd_pending_o), .retire_o(retire_o),
`ifdef WB_TRACE_EN
        .debug_wb_pc_o(debug_wb_pc_o), .debug_wb_rf_we_o(debug_wb_rf_we_o),
        .debug_wb_rf_wnum_o(debug_wb_rf_wnum_o), .debug_wb_rf_wdata_o(debug_wb_rf_wdata_o),
`endif
        .retire_pc_o(retire_pc_o)
    );

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic we, input logic [31:0] res,
                             input logic [31:0] pc);
        mem_valid_i = 1'b1; mem_is_load_i = 1'b0; mem_rd_i = rd; mem_rf_we_i = we;
        mem_result_i = res; mem_pc_i = pc; mem_load_op_i = 3'b000; mem_addr_lo_i = 2'b00;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [2:0] op, input logic [1:0] lo,
                              input logic [31:0] pc);
        mem_valid_i = 1'b1; mem_is_load_i = 1'b1; mem_rd_i = rd; mem_rf_we_i = 1'b1;
        mem_result_i = 32'hDEAD_BEEF; mem_pc_i = pc; mem_load_op_i = op; mem_addr_lo_i = lo;
    endtask

    task automatic idle_inputs();
        mem_valid_i = 1'b0; mem_is_load_i = 1'b0; mem_rd_i = '0; mem_rf_we_i = 1'b0;
        mem_result_i = '0; mem_pc_i = '0; mem_load_op_i = '0; mem_addr_lo_i = '0;
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        idle_inputs();
        rst_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
        obs = {mem_ready_o, rf_we_o, fwd_valid_o, fwd_pending_o, retire_o, 27'd0};
        total++;
        if (obs !== 32'h8000_0000) $display("FAIL reset_ctrl got=%h exp=%h", obs, 32'h8000_0000);
        else passed++;
        total++;
        if ({rf_waddr_o, rf_wdata_o, fwd_rd_o, fwd_data_o, retire_pc_o} !== 138'd0)
            $display("FAIL reset_data waddr=%0d wdata=%h pc=%h exp all zero", rf_waddr_o, rf_wdata_o, retire_pc_o);
        else passed++;
    endtask

    task automatic test_alu();
        drive_alu(5'd5, 1'b1, 32'h1234_5678, 32'h0000_0100);
        step();
        idle_inputs();
        total++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o, retire_o, retire_pc_o} !== {1'b1, 5'd5, 32'h1234_5678, 1'b1, 32'h0000_0100})
            $display("FAIL alu_write we=%b waddr=%0d wdata=%h ret=%b pc=%h exp 1/5/12345678/1/00000100",
                     rf_we_o, rf_waddr_o, rf_wdata_o, retire_o, retire_pc_o);
        else passed++;
        total++;
        if ({fwd_valid_o, fwd_rd_o, fwd_data_o} !== {1'b1, 5'd5, 32'h1234_5678})
            $display("FAIL alu_fwd v=%b rd=%0d data=%h exp 1/5/12345678", fwd_valid_o, fwd_rd_o, fwd_data_o);
        else passed++;
        step();
        total++;
        if ({rf_we_o, retire_o, fwd_valid_o, mem_ready_o} !== 4'b0001)
            $display("FAIL alu_idle we/ret/fv/rdy=%b exp 0001", {rf_we_o, retire_o, fwd_valid_o, mem_ready_o});
        else passed++;
    endtask

    task automatic test_lb_sign();
        drive_load(5'd7, 3'b000, 2'd2, 32'h0000_0200);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({mem_ready_o, fwd_pending_o, fwd_rd_o, rf_we_o, retire_o, fwd_valid_o} !== {1'b0, 1'b1, 5'd7, 3'b000})
                $display("FAIL lb_wait cyc=%0d rdy=%b pend=%b frd=%0d we=%b ret=%b exp 0/1/7/0/0",
                         i, mem_ready_o, fwd_pending_o, fwd_rd_o, rf_we_o, retire_o);
            else passed++;
            if (i < 2) step();
        end
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0080_FF11;
        step();
        idle_inputs();
        total++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o, retire_o, retire_pc_o, mem_ready_o} !==
            {1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 32'h0000_0200, 1'b1})
            $display("FAIL lb_write we=%b waddr=%0d wdata=%h ret=%b pc=%h exp 1/7/ffffff80/1/00000200",
                     rf_we_o, rf_waddr_o, rf_wdata_o, retire_o, retire_pc_o);
        else passed++;
        step();
    endtask

    task automatic run_load(input logic [2:0] op, input logic [1:0] lo, input logic [31:0] raw,
                            input logic [31:0] exp_data, input string name);
        drive_load(5'd12, op, lo, 32'h0000_0300);
        step();
        idle_inputs();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = raw;
        step();
        idle_inputs();
        total++;
        if (rf_wdata_o !== exp_data || rf_we_o !== 1'b1)
            $display("FAIL %s wdata=%h we=%b exp %h/1", name, rf_wdata_o, rf_we_o, exp_data);
        else passed++;
        step();
    endtask

    task automatic test_load_ext();
        run_load(3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001, "lhu_hi");
        run_load(3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001, "lh_hi");
        run_load(3'b001, 2'd1, 32'h0000_C0DE, 32'hFFFF_C0DE, "lh_lo_ignore_bit0");
        run_load(3'b100, 2'd3, 32'h9A00_0000, 32'h0000_009A, "lbu_b3");
        run_load(3'b000, 2'd0, 32'h1234_567F, 32'h0000_007F, "lb_pos");
        run_load(3'b010, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D, "lw");
        run_load(3'b111, 2'd1, 32'h8765_4321, 32'h8765_4321, "undef_op_as_lw");
    endtask

    task automatic test_rd_zero();
        drive_alu(5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0400);
        step();
        idle_inputs();
        total++;
        if ({rf_we_o, fwd_valid_o, retire_o, retire_pc_o} !== {1'b0, 1'b0, 1'b1, 32'h0000_0400})
            $display("FAIL rd_zero we=%b fv=%b ret=%b pc=%h exp 0/0/1/00000400",
                     rf_we_o, fwd_valid_o, retire_o, retire_pc_o);
        else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive_alu(5'(i + 1), 1'b1, 32'h100 + i, 32'h1000 + 4 * i);
            step();
            total++;
            if ({rf_we_o, rf_waddr_o, rf_wdata_o, retire_pc_o, mem_ready_o} !==
                {1'b1, 5'(i + 1), 32'h100 + i, 32'h1000 + 4 * i, 1'b1})
                $display("FAIL b2b_alu%0d we=%b waddr=%0d wdata=%h pc=%h rdy=%b", i,
                         rf_we_o, rf_waddr_o, rf_wdata_o, retire_pc_o, mem_ready_o);
            else passed++;
        end
        drive_load(5'd10, 3'b010, 2'd0, 32'h1010);
        step();
        // Next instruction is presented and must be held until the load completes.
        drive_alu(5'd11, 1'b1, 32'h0000_0BBB, 32'h1014);
        total++;
        if ({mem_ready_o, rf_we_o, retire_o} !== 3'b000)
            $display("FAIL b2b_load_wait rdy/we/ret=%b exp 000", {mem_ready_o, rf_we_o, retire_o});
        else passed++;
        step();
        total++;
        if ({mem_ready_o, rf_we_o, retire_o, fwd_pending_o} !== 4'b0001)
            $display("FAIL b2b_hold rdy/we/ret/pend=%b exp 0001", {mem_ready_o, rf_we_o, retire_o, fwd_pending_o});
        else passed++;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hAAAA_0001;
        step();
        dmem_rvalid_i = 1'b0;
        total++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o, retire_pc_o, mem_ready_o} !== {1'b1, 5'd10, 32'hAAAA_0001, 32'h1010, 1'b1})
            $display("FAIL b2b_load_wr we=%b waddr=%0d wdata=%h pc=%h rdy=%b",
                     rf_we_o, rf_waddr_o, rf_wdata_o, retire_pc_o, mem_ready_o);
        else passed++;
        step();
        idle_inputs();
        total++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o, retire_pc_o} !== {1'b1, 5'd11, 32'h0000_0BBB, 32'h1014})
            $display("FAIL b2b_after_load we=%b waddr=%0d wdata=%h pc=%h",
                     rf_we_o, rf_waddr_o, rf_wdata_o, retire_pc_o);
        else passed++;
        step();
    endtask

    task automatic test_reset_mid_load();
        drive_load(5'd9, 3'b010, 2'd0, 32'h2000);
        step();
        idle_inputs();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        total++;
        if ({mem_ready_o, fwd_pending_o, rf_we_o} !== 3'b100)
            $display("FAIL rst_mid_load rdy/pend/we=%b exp 100", {mem_ready_o, fwd_pending_o, rf_we_o});
        else passed++;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
        step();
        dmem_rvalid_i = 1'b0;
        total++;
        if ({rf_we_o, retire_o, fwd_valid_o, mem_ready_o} !== 4'b0001)
            $display("FAIL spurious_rvalid we/ret/fv/rdy=%b exp 0001", {rf_we_o, retire_o, fwd_valid_o, mem_ready_o});
        else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb_sign();
        test_load_ext();
        test_rd_zero();
        test_back_to_back();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
